// File: rtl/fir_seq_param.sv
// Time-multiplexed FIR filter: one signed MAC walks N_TAPS taps per accepted sample.
// Coefficients are loaded serially at run time. The result is shifted and saturated.
module fir_seq_param #(
  parameter int N_TAPS = 16,
  parameter int DATA_W = 12,
  parameter int COEF_W = 12,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     coef_load_i,
  input  logic signed [COEF_W-1:0] coef_i,
  input  logic                     coef_valid_i,
  output logic                     coef_loaded_o,
  input  logic signed [DATA_W-1:0] sample_i,
  input  logic                     sample_valid_i,
  output logic                     sample_ready_o,
  output logic signed [OUT_W-1:0]  data_o,
  output logic                     data_valid_o
);
  localparam int IDX_W  = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = PROD_W + $clog2(N_TAPS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_TAPS - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_MAC, S_OUT} state_t;

  state_t                   state_q, state_d;
  logic signed [COEF_W-1:0] coef_q [N_TAPS];
  logic signed [DATA_W-1:0] x_q    [N_TAPS];
  logic        [IDX_W-1:0]  idx_q;
  logic signed [ACC_W-1:0]  acc_q;

  logic                     accept, coef_wr, mac_en, out_en, last_idx;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext, shifted;
  logic signed [OUT_W-1:0]  sat_val;

  assign last_idx = (idx_q == LAST_IDX);

  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path infers a latch.
  always_comb begin
    state_d        = state_q;
    accept         = 1'b0;
    coef_wr        = 1'b0;
    mac_en         = 1'b0;
    out_en         = 1'b0;
    sample_ready_o = 1'b0;
    if (coef_load_i) begin
      // A reload request beats everything else, including a waiting sample.
      state_d = S_LOAD;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          sample_ready_o = coef_loaded_o;
          if (sample_valid_i && coef_loaded_o) begin
            accept  = 1'b1;
            state_d = S_MAC;
          end
        end
        S_LOAD: begin
          if (coef_valid_i) begin
            coef_wr = 1'b1;
            if (last_idx) state_d = S_IDLE;
          end
        end
        S_MAC: begin
          mac_en = 1'b1;
          if (last_idx) state_d = S_OUT;
        end
        S_OUT: begin
          out_en  = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    prod     = PROD_W'(coef_q[idx_q]) * PROD_W'(x_q[idx_q]);
    prod_ext = ACC_W'(prod);
    shifted  = acc_q >>> SHIFT;
  end

  generate
    if (OUT_W >= ACC_W) begin : g_no_sat
      assign sat_val = OUT_W'(shifted);
    end else begin : g_sat
      // In range exactly when all bits above the output sign bit match it.
      always_comb begin
        if (shifted[ACC_W-1:OUT_W-1] == '0 || shifted[ACC_W-1:OUT_W-1] == '1)
          sat_val = shifted[OUT_W-1:0];
        else if (shifted[ACC_W-1])
          sat_val = {1'b1, {(OUT_W-1){1'b0}}};
        else
          sat_val = {1'b0, {(OUT_W-1){1'b1}}};
      end
    end
  endgenerate

  // NOTE: coefficient and delay-line storage is reset explicitly; a restart must see a zero history.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int k = 0; k < N_TAPS; k++) begin
        coef_q[k] <= '0;
        x_q[k]    <= '0;
      end
      idx_q         <= '0;
      acc_q         <= '0;
      coef_loaded_o <= 1'b0;
      data_o        <= '0;
      data_valid_o  <= 1'b0;
    end else begin
      data_valid_o <= 1'b0;
      if (coef_load_i) begin
        for (int k = 0; k < N_TAPS; k++) x_q[k] <= '0;
        idx_q         <= '0;
        coef_loaded_o <= 1'b0;
      end else begin
        if (accept) begin
          for (int k = N_TAPS - 1; k > 0; k--) x_q[k] <= x_q[k-1];
          x_q[0] <= sample_i;
          acc_q  <= '0;
          idx_q  <= '0;
        end
        if (coef_wr) begin
          coef_q[idx_q] <= coef_i;
          idx_q         <= last_idx ? '0 : idx_q + 1'b1;
          if (last_idx) coef_loaded_o <= 1'b1;
        end
        if (mac_en) begin
          acc_q <= acc_q + prod_ext;
          idx_q <= last_idx ? '0 : idx_q + 1'b1;
        end
        if (out_en) begin
          data_o       <= sat_val;
          data_valid_o <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/fir_seq_param.md
# fir_seq_param

Parametrised, time-multiplexed FIR filter: a single signed multiplier-accumulator iterates over `N_TAPS` taps per input sample. Coefficients are loaded serially at run time, and the result is scaled and saturated. It sits between the ADC sample stream and the output FIFO, and replaces the fixed 16-tap, 12-bit filter. Unlike that filter, the number of taps, the data and coefficient widths, the output width and the scaling shift are all generic. A valid/ready sample handshake and saturation on the output are also new.

## Interface

Parameters:

- `N_TAPS`, 16, number of taps, 2..64
- `DATA_W`, 12, signed input sample width
- `COEF_W`, 12, signed coefficient width
- `OUT_W`, 16, signed output width
- `SHIFT`, 8, arithmetic right shift applied to the accumulator before saturation

Ports:

- `clk_i` in 1: the single clock. All logic is on its rising edge.
- `rst_i` in 1: asynchronous, active-low reset.
- `coef_load_i` in 1: one-cycle pulse that starts a coefficient reload.
- `coef_i` in `COEF_W`: signed coefficient word.
- `coef_valid_i` in 1: `coef_i` is valid this cycle.
- `coef_loaded_o` out 1: high when all `N_TAPS` coefficients are loaded.
- `sample_i` in `DATA_W`: signed input sample.
- `sample_valid_i` in 1: `sample_i` is valid this cycle.
- `sample_ready_o` out 1: the block can accept a sample this cycle.
- `data_o` out `OUT_W`: signed filtered output, held until the next result.
- `data_valid_o` out 1: one-cycle pulse marking a new `data_o`.

## Operation

**Reset (`rst_i` = 0)**
- State goes to IDLE.
- All coefficients and the whole delay line clear to 0.
- The tap index and the accumulator clear to 0.
- Outputs: `coef_loaded_o`=0, `sample_ready_o`=0, `data_o`=0, `data_valid_o`=0.

**State machine: IDLE, LOAD, MAC, OUT**

- **IDLE**
  - `sample_ready_o` = `coef_loaded_o`.
  - When `sample_valid_i` && `sample_ready_o`: shift the delay line (`x[k]`←`x[k-1]`, `x[0]`←`sample_i`), clear the accumulator and tap index, go to MAC.
- **LOAD**
  - Entered from any state the cycle after `coef_load_i`=1. Entry aborts any MAC in progress with no output, clears the delay line and tap index, and sets `coef_loaded_o`=0.
  - Each cycle with `coef_valid_i`=1 writes `coef[idx]`←`coef_i` and increments `idx`.
  - The write with `idx`=`N_TAPS`-1 sets `coef_loaded_o`=1 and returns to IDLE.
  - `coef_valid_i` outside LOAD is ignored.
- **MAC**
  - One tap per cycle: `acc` += `coef[idx]`·`x[idx]`, for `idx` = 0..`N_TAPS`-1.
  - After the last tap, go to OUT.
- **OUT**
  - Register `data_o` = sat(`acc` >>> `SHIFT`) and pulse `data_valid_o`.
  - Go to IDLE.

**Arithmetic**
- Product width is `DATA_W`+`COEF_W`.
- Accumulator width is `DATA_W`+`COEF_W`+clog2(`N_TAPS`), so it never overflows.
- Shift is arithmetic and truncating, with no rounding.
- Saturation clamps to [-2^(`OUT_W`-1), 2^(`OUT_W`-1)-1].
- `coef[0]` multiplies the newest sample.

**Boundary conditions**
- `sample_valid_i` while `sample_ready_o`=0 is ignored. It is not buffered, and the upstream source must hold it.
- `coef_load_i` and `sample_valid_i` in the same cycle: the load wins and the sample is not accepted.
- `coef_load_i` during LOAD restarts the load at `idx`=0.

## Timing

- Sample accepted at edge T.
- MAC runs on edges T+1..T+`N_TAPS`.
- `data_o` and `data_valid_o` update at edge T+`N_TAPS`+1.
- `sample_ready_o` is high again from T+`N_TAPS`+2.
- Throughput is one sample per `N_TAPS`+2 cycles (18 at default parameters).
- `coef_loaded_o` rises on the edge that writes the last coefficient.
- `data_valid_o` is high for exactly one cycle per accepted sample.
- Reset takes effect immediately, asynchronously. Release is synchronous to `clk_i`.

## Test plan

- **Impulse response.** Load coefficients 1..16, feed one sample of 256 then zeros (default parameters).
  - Required: 16 consecutive outputs of 1, 2, …, 16. Each is (256·k)>>>8.
  - Each output arrives 17 cycles after acceptance.
  - Accepted samples are spaced 18 cycles apart.
- **Saturation.** All 16 coefficients = 2047, feed a constant 2047 until the delay line is full.
  - Required: `data_o` = 32767.
  - With all coefficients = -2048 and samples = 2047: `data_o` = -32768.
- **Handshake.**
  - Before load completes: `sample_ready_o`=0, and 100 cycles of `sample_valid_i`=1 produce no `data_valid_o`.
  - After load, a sample held valid across the MAC is accepted exactly once per 18 cycles.
- **Reload abort.** Assert `coef_load_i` during MAC cycle 5.
  - Required: no `data_valid_o` pulse, and `coef_loaded_o` falls the next cycle.
  - After 16 new coefficients the delay line reads zeros: a first sample of 256 with coefficient[0]=3 gives `data_o`=3.
- **Reset mid-operation.** Pull `rst_i` low during OUT.
  - Required: `data_valid_o` and `data_o` go to 0 immediately (no clock edge needed), and `coef_loaded_o`=0.
  - After release, samples are refused until a full reload.
- **Parameter sweep.** Use `N_TAPS`=4, `DATA_W`=8, `COEF_W`=8, `OUT_W`=10, `SHIFT`=0.
  - Required: outputs match a bit-exact reference model on 1000 random samples.
  - Latency is 5 cycles and the sample interval is 6 cycles.
